// File: rtl/alarm_buzzer.sv
// Alarm sounder: steady, siren and beep tone patterns on the piezo pin plus alarm LED,
// with an optional ring timeout that ends in a one-cycle done pulse.
module alarm_buzzer #(
  parameter int CLK_HZ          = 100000000,
  parameter int TONE_LO_HZ      = 440,
  parameter int TONE_HI_HZ      = 880,
  parameter int SWITCH_CYCLES   = 8388608,
  parameter int BEEP_ON_CYCLES  = 25000000,
  parameter int BEEP_OFF_CYCLES = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic [1:0] mode,
  input  logic [7:0] ring_secs,
  output logic       speaker,
  output logic       light,
  output logic       busy,
  output logic       done
);

  localparam int HALF_LO  = CLK_HZ / (2 * TONE_LO_HZ);
  localparam int HALF_HI  = CLK_HZ / (2 * TONE_HI_HZ);
  localparam int HALF_MAX = (HALF_LO > HALF_HI) ? HALF_LO : HALF_HI;
  localparam int BEEP_MAX = (BEEP_ON_CYCLES > BEEP_OFF_CYCLES) ? BEEP_ON_CYCLES : BEEP_OFF_CYCLES;

  localparam int DIV_W   = (HALF_MAX > 1) ? $clog2(HALF_MAX) : 1;
  localparam int SIREN_W = (SWITCH_CYCLES > 1) ? $clog2(SWITCH_CYCLES) : 1;
  localparam int BEEP_W  = (BEEP_MAX > 1) ? $clog2(BEEP_MAX) : 1;
  localparam int SEC_W   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

  localparam logic [DIV_W-1:0]   RELOAD_LO  = DIV_W'(HALF_LO - 1);
  localparam logic [DIV_W-1:0]   RELOAD_HI  = DIV_W'(HALF_HI - 1);
  localparam logic [SIREN_W-1:0] SIREN_LAST = SIREN_W'(SWITCH_CYCLES - 1);
  localparam logic [BEEP_W-1:0]  ON_LAST    = BEEP_W'(BEEP_ON_CYCLES - 1);
  localparam logic [BEEP_W-1:0]  OFF_LAST   = BEEP_W'(BEEP_OFF_CYCLES - 1);
  localparam logic [SEC_W-1:0]   SEC_LAST   = SEC_W'(CLK_HZ - 1);

  typedef enum logic {IDLE, RING} state_t;

  state_t state_q, state_d;

  logic [DIV_W-1:0]   div_cnt, div_d;
  logic [SIREN_W-1:0] siren_cnt, siren_d;
  logic [BEEP_W-1:0]  beep_cnt, beep_cnt_d;
  logic [SEC_W-1:0]   sec_cnt, sec_d;
  logic [7:0]         elapsed, elapsed_d;
  logic [7:0]         secs_q, secs_d;
  logic [1:0]         mode_q, mode_d, mode_n;
  logic               tone_hi, tone_hi_d;
  logic               beep_on, beep_on_d;
  logic               speaker_d, light_d, busy_d, done_d;
  logic               start_go, stop_go, timeout, gated;
  logic [DIV_W-1:0]   reload_cur;

  assign mode_n     = (mode == 2'd3) ? 2'd0 : mode;
  assign start_go   = start & ~stop;
  assign stop_go    = stop & (state_q == RING);
  assign timeout    = (state_q == RING) && (secs_q != 8'd0) && (sec_cnt == SEC_LAST)
                      && (elapsed == secs_q - 8'd1);
  assign gated      = (mode_q == 2'd2);
  assign reload_cur = (gated || ((mode_q == 2'd1) && tone_hi)) ? RELOAD_HI : RELOAD_LO;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (start_go)                state_d = RING;
    else if (stop_go || timeout) state_d = IDLE;
  end

  always_comb begin
    div_d      = div_cnt;
    siren_d    = siren_cnt;
    beep_cnt_d = beep_cnt;
    sec_d      = sec_cnt;
    elapsed_d  = elapsed;
    secs_d     = secs_q;
    mode_d     = mode_q;
    tone_hi_d  = tone_hi;
    beep_on_d  = beep_on;
    speaker_d  = speaker;
    busy_d     = busy;
    done_d     = 1'b0;

    if (start_go) begin
      busy_d     = 1'b1;
      div_d      = (mode_n == 2'd2) ? RELOAD_HI : RELOAD_LO;
      speaker_d  = 1'b0;
      tone_hi_d  = 1'b0;
      siren_d    = '0;
      beep_cnt_d = '0;
      beep_on_d  = 1'b1;
      sec_d      = '0;
      elapsed_d  = '0;
      mode_d     = mode_n;
      secs_d     = ring_secs;
    end else if (stop_go || timeout) begin
      busy_d    = 1'b0;
      speaker_d = 1'b0;
      done_d    = timeout & ~stop_go;
    end else if (state_q == RING) begin
      // A ring_secs of zero freezes the timer so the alarm rings until stopped.
      if (secs_q != 8'd0) begin
        if (sec_cnt == SEC_LAST) begin
          sec_d     = '0;
          elapsed_d = elapsed + 8'd1;
        end else begin
          sec_d = sec_cnt + 1'b1;
        end
      end

      if (mode_q == 2'd1) begin
        if (siren_cnt == SIREN_LAST) begin
          siren_d   = '0;
          tone_hi_d = ~tone_hi;
        end else begin
          siren_d = siren_cnt + 1'b1;
        end
      end

      if (gated) begin
        if (beep_on) begin
          if (beep_cnt == ON_LAST) begin
            beep_on_d  = 1'b0;
            beep_cnt_d = '0;
          end else begin
            beep_cnt_d = beep_cnt + 1'b1;
          end
        end else if (beep_cnt == OFF_LAST) begin
          beep_on_d  = 1'b1;
          beep_cnt_d = '0;
        end else begin
          beep_cnt_d = beep_cnt + 1'b1;
        end
      end

      // Holding the divider at reload while silent makes each ON phase restart like a fresh start.
      if (gated && !(beep_on && beep_on_d)) begin
        speaker_d = 1'b0;
        div_d     = RELOAD_HI;
      end else if (div_cnt == '0) begin
        speaker_d = ~speaker;
        div_d     = reload_cur;
      end else begin
        div_d = div_cnt - 1'b1;
      end
    end

    light_d = busy_d & ((mode_d != 2'd2) | beep_on_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt   <= '0;
      siren_cnt <= '0;
      beep_cnt  <= '0;
      sec_cnt   <= '0;
      elapsed   <= '0;
      secs_q    <= '0;
      mode_q    <= '0;
      tone_hi   <= 1'b0;
      beep_on   <= 1'b0;
      speaker   <= 1'b0;
      light     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      div_cnt   <= div_d;
      siren_cnt <= siren_d;
      beep_cnt  <= beep_cnt_d;
      sec_cnt   <= sec_d;
      elapsed   <= elapsed_d;
      secs_q    <= secs_d;
      mode_q    <= mode_d;
      tone_hi   <= tone_hi_d;
      beep_on   <= beep_on_d;
      speaker   <= speaker_d;
      light     <= light_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

endmodule

// File: tb/tb_alarm_buzzer.sv
// Directed bench for alarm_buzzer with small clock/tone parameters so whole rings fit in a short run.
module tb_alarm_buzzer;

  logic       clk = 1'b0;
  logic       rst, start, stop;
  logic [1:0] mode;
  logic [7:0] ring_secs;
  logic       speaker, light, busy, done;

  int checks = 0;
  int errors = 0;

  alarm_buzzer #(
    .CLK_HZ(1000), .TONE_LO_HZ(50), .TONE_HI_HZ(100),
    .SWITCH_CYCLES(40), .BEEP_ON_CYCLES(30), .BEEP_OFF_CYCLES(20)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode),
    .ring_secs(ring_secs), .speaker(speaker), .light(light), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [3:0] expected);
    logic [3:0] observed;
    observed = {speaker, light, busy, done};
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed spk/led/busy/done=%b expected=%b", tag, observed, expected);
    end
  endtask

  task automatic checkValue(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Called at a falling edge; inputs are sampled at the next rising edge, and we return
  // at the falling edge right after it.
  task automatic applyStimulus(input logic s, input logic p, input logic [1:0] m, input logic [7:0] secs);
    start = s; stop = p; mode = m; ring_secs = secs;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic countActivity(input int n, output int dones, output int busies);
    dones = 0; busies = 0;
    repeat (n) begin
      @(negedge clk);
      if (done) dones++;
      if (busy) busies++;
    end
  endtask

  initial begin
    int k, prev, last, ntog, bad, d, b;
    int tog[13];
    int exp_tog[13] = '{10, 20, 30, 40, 50, 55, 60, 65, 70, 75, 80, 85, 95};
    int p;
    logic exp_spk, exp_led;

    rst = 1'b1; start = 1'b0; stop = 1'b0; mode = 2'd0; ring_secs = 8'd0;
    tick(3);
    checkOutput("reset", 4'b0000);
    rst = 1'b0;
    tick(1);
    checkOutput("idle after reset", 4'b0000);

    // Steady tone, 2 s; later changes to mode/ring_secs must be ignored.
    applyStimulus(1'b1, 1'b0, 2'd0, 8'd2);
    checkOutput("steady k0", 4'b0110);
    mode = 2'd2; ring_secs = 8'd5;
    tick(9);  checkOutput("steady k9", 4'b0110);
    tick(1);  checkOutput("steady k10 first rise", 4'b1110);
    tick(10); checkOutput("steady k20", 4'b0110);
    tick(10); checkOutput("steady k30", 4'b1110);
    k = 30;
    while (busy && k < 2100) begin
      @(negedge clk);
      k++;
    end
    checkValue("steady busy length", k, 2000);
    checkOutput("steady done pulse", 4'b0001);
    tick(1);
    checkOutput("steady after done", 4'b0000);

    // Siren, no timeout.
    applyStimulus(1'b1, 1'b0, 2'd1, 8'd0);
    prev = speaker; last = 0; ntog = 0; bad = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (speaker != prev[0]) begin
        if (ntog < 13) tog[ntog] = i;
        ntog++;
        if ((i - last) != 5 && (i - last) != 10) bad++;
        last = i;
        prev = speaker;
      end
    end
    for (int i = 0; i < 13; i++) checkValue($sformatf("siren toggle %0d time", i), tog[i], exp_tog[i]);
    checkValue("siren off-grid half periods", bad, 0);
    tick(900);
    checkValue("siren led/busy/done past 1s", {29'd0, light, busy, done}, 6);
    applyStimulus(1'b0, 1'b1, 2'd0, 8'd0);
    checkOutput("siren stop", 4'b0000);

    // Beep: 30 cycles of 5-cycle toggling, 20 cycles silent, repeating.
    applyStimulus(1'b1, 1'b0, 2'd2, 8'd0);
    for (int i = 0; i < 120; i++) begin
      p = i % 50;
      exp_led = (p < 30);
      exp_spk = (p < 30) ? (((p / 5) % 2) == 1) : 1'b0;
      checkOutput($sformatf("beep k%0d", i), {exp_spk, exp_led, 1'b1, 1'b0});
      @(negedge clk);
    end
    applyStimulus(1'b0, 1'b1, 2'd0, 8'd0);
    checkOutput("beep stop", 4'b0000);

    // Start and stop together in IDLE, stop in IDLE, stop mid-ring.
    applyStimulus(1'b1, 1'b1, 2'd0, 8'd1);
    checkOutput("start+stop in idle", 4'b0000);
    tick(5);
    checkOutput("still idle", 4'b0000);
    applyStimulus(1'b0, 1'b1, 2'd0, 8'd1);
    checkOutput("stop in idle", 4'b0000);
    applyStimulus(1'b1, 1'b0, 2'd0, 8'd1);
    checkOutput("ring before stop", 4'b0110);
    tick(100);
    applyStimulus(1'b0, 1'b1, 2'd0, 8'd1);
    checkOutput("stop mid ring", 4'b0000);
    countActivity(1100, d, b);
    checkValue("done after stop", d, 0);
    checkValue("busy after stop", b, 0);

    // Restart at cycle 1500 of a 2 s ring.
    applyStimulus(1'b1, 1'b0, 2'd0, 8'd2);
    countActivity(1500, d, b);
    checkValue("restart first-run done", d, 0);
    checkValue("restart first-run busy", b, 1500);
    applyStimulus(1'b1, 1'b0, 2'd0, 8'd2);
    checkOutput("restart k0", 4'b0110);
    k = 0;
    while (busy && k < 2100) begin
      @(negedge clk);
      k++;
    end
    checkValue("restart busy length", k, 2000);
    checkOutput("restart done pulse", 4'b0001);
    countActivity(20, d, b);
    checkValue("restart extra done", d, 0);

    // Mode 3 behaves as mode 0; reset mid-ring silences without done.
    applyStimulus(1'b1, 1'b0, 2'd3, 8'd1);
    tick(9); checkOutput("mode3 k9", 4'b0110);
    tick(1); checkOutput("mode3 k10", 4'b1110);
    tick(10); checkOutput("mode3 k20", 4'b0110);
    tick(30);
    rst = 1'b1;
    tick(1);
    checkOutput("reset mid ring", 4'b0000);
    rst = 1'b0;
    countActivity(1100, d, b);
    checkValue("done after reset", d, 0);
    checkValue("busy after reset", b, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
